// File: rtl/id_stage_pkg.sv
// Shared decode constants for the ID stage: instruction opcode/funct values,
// ALU opcode/select encodings, decoded-instruction record and operand mux helper.
package id_stage_pkg;

   localparam int INST_W   = 32;
   localparam int REG_AW   = 5;
   localparam int ALUOP_W  = 8;
   localparam int ALUSEL_W = 3;

   localparam logic [INST_W-1:0] ZeroWord   = 32'h0000_0000;
   localparam logic [REG_AW-1:0] NopRegAddr = 5'd0;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_XORI    = 6'b001110;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;

   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_XOR  = 6'b100110;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_SRA  = 6'b000011;

   typedef enum logic [ALUOP_W-1:0] {
      ALU_NOP   = 8'b0000_0000,
      ALU_AND   = 8'b0010_0100,
      ALU_OR    = 8'b0010_0101,
      ALU_XOR   = 8'b0010_0110,
      ALU_NOR   = 8'b0010_0111,
      ALU_ADDU  = 8'b0010_0001,
      ALU_SUBU  = 8'b0010_0011,
      ALU_SLT   = 8'b0010_1010,
      ALU_SLL   = 8'b0111_1100,
      ALU_SRL   = 8'b0000_0010,
      ALU_SRA   = 8'b0000_0011,
      ALU_ADDIU = 8'b0101_0110,
      ALU_LW    = 8'b1110_0011,
      ALU_SW    = 8'b1110_1011
   } aluop_e;

   typedef enum logic [ALUSEL_W-1:0] {
      SEL_NOP   = 3'b000,
      SEL_LOGIC = 3'b001,
      SEL_SHIFT = 3'b010,
      SEL_ARITH = 3'b100,
      SEL_LDST  = 3'b111
   } alusel_e;

   // imm1/imm2 are what each operand port carries when its read is disabled.
   typedef struct packed {
      aluop_e             aluop;
      alusel_e            alusel;
      logic               re1;
      logic               re2;
      logic [REG_AW-1:0]  ra1;
      logic [REG_AW-1:0]  ra2;
      logic               wreg;
      logic [REG_AW-1:0]  wd;
      logic [INST_W-1:0]  imm1;
      logic [INST_W-1:0]  imm2;
   } dec_t;

   function automatic logic [INST_W-1:0] sel_operand(
      input logic              re,
      input logic [REG_AW-1:0] addr,
      input logic [INST_W-1:0] imm,
      input logic              ex_wreg,
      input logic [REG_AW-1:0] ex_wd,
      input logic [INST_W-1:0] ex_wdata,
      input logic              mem_wreg,
      input logic [REG_AW-1:0] mem_wd,
      input logic [INST_W-1:0] mem_wdata,
      input logic [INST_W-1:0] rdata
   );
      logic [INST_W-1:0] v;
      if (!re) begin
         v = imm;
      end else if (addr == NopRegAddr) begin
         v = ZeroWord;
      end else if (ex_wreg && (ex_wd == addr)) begin
         v = ex_wdata;
      end else if (mem_wreg && (mem_wd == addr)) begin
         v = mem_wdata;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

endpackage

// File: rtl/id_decode.sv
// Pure combinational field decode of one MIPS instruction word into ALU
// opcode/select, read-port usage, destination and immediates.
module id_decode
   import id_stage_pkg::*;
(
   input  logic [INST_W-1:0] i_inst,
   output dec_t              o_dec
);

   logic [5:0]        w_op;
   logic [5:0]        w_fn;
   logic [REG_AW-1:0] w_rs;
   logic [REG_AW-1:0] w_rt;
   logic [REG_AW-1:0] w_rd;
   logic [4:0]        w_sa;
   logic [15:0]       w_imm;

   assign w_op  = i_inst[31:26];
   assign w_rs  = i_inst[25:21];
   assign w_rt  = i_inst[20:16];
   assign w_rd  = i_inst[15:11];
   assign w_sa  = i_inst[10:6];
   assign w_fn  = i_inst[5:0];
   assign w_imm = i_inst[15:0];

   // Field decode; unsupported encodings fall through to the NOP defaults.
   always_comb begin
      o_dec.aluop  = ALU_NOP;
      o_dec.alusel = SEL_NOP;
      o_dec.re1    = 1'b0;
      o_dec.re2    = 1'b0;
      o_dec.ra1    = w_rs;
      o_dec.ra2    = w_rt;
      o_dec.wreg   = 1'b0;
      o_dec.wd     = NopRegAddr;
      o_dec.imm1   = ZeroWord;
      o_dec.imm2   = ZeroWord;
      case (w_op)
         OP_SPECIAL: begin
            o_dec.re1  = 1'b1;
            o_dec.re2  = 1'b1;
            o_dec.wreg = 1'b1;
            o_dec.wd   = w_rd;
            case (w_fn)
               FN_AND:  begin o_dec.aluop = ALU_AND;  o_dec.alusel = SEL_LOGIC; end
               FN_OR:   begin o_dec.aluop = ALU_OR;   o_dec.alusel = SEL_LOGIC; end
               FN_XOR:  begin o_dec.aluop = ALU_XOR;  o_dec.alusel = SEL_LOGIC; end
               FN_NOR:  begin o_dec.aluop = ALU_NOR;  o_dec.alusel = SEL_LOGIC; end
               FN_ADDU: begin o_dec.aluop = ALU_ADDU; o_dec.alusel = SEL_ARITH; end
               FN_SUBU: begin o_dec.aluop = ALU_SUBU; o_dec.alusel = SEL_ARITH; end
               FN_SLT:  begin o_dec.aluop = ALU_SLT;  o_dec.alusel = SEL_ARITH; end
               FN_SLL, FN_SRL, FN_SRA: begin
                  o_dec.aluop  = (w_fn == FN_SLL) ? ALU_SLL :
                                 (w_fn == FN_SRL) ? ALU_SRL : ALU_SRA;
                  o_dec.alusel = SEL_SHIFT;
                  o_dec.re1    = 1'b0;
                  o_dec.imm1   = {27'd0, w_sa};
               end
               default: begin
                  o_dec.re1  = 1'b0;
                  o_dec.re2  = 1'b0;
                  o_dec.wreg = 1'b0;
                  o_dec.wd   = NopRegAddr;
               end
            endcase
         end
         OP_ORI, OP_ANDI, OP_XORI: begin
            o_dec.aluop  = (w_op == OP_ORI)  ? ALU_OR :
                           (w_op == OP_ANDI) ? ALU_AND : ALU_XOR;
            o_dec.alusel = SEL_LOGIC;
            o_dec.re1    = 1'b1;
            o_dec.wreg   = 1'b1;
            o_dec.wd     = w_rt;
            o_dec.imm2   = {16'h0000, w_imm};
         end
         OP_ADDIU: begin
            o_dec.aluop  = ALU_ADDIU;
            o_dec.alusel = SEL_ARITH;
            o_dec.re1    = 1'b1;
            o_dec.wreg   = 1'b1;
            o_dec.wd     = w_rt;
            o_dec.imm2   = {{16{w_imm[15]}}, w_imm};
         end
         OP_LUI: begin
            // rs is not read: reg1 stays 0, so the OR yields the shifted immediate.
            o_dec.aluop  = ALU_OR;
            o_dec.alusel = SEL_LOGIC;
            o_dec.wreg   = 1'b1;
            o_dec.wd     = w_rt;
            o_dec.imm2   = {w_imm, 16'h0000};
         end
         OP_LW, OP_SW: begin
            o_dec.aluop  = (w_op == OP_LW) ? ALU_LW : ALU_SW;
            o_dec.alusel = SEL_LDST;
            o_dec.re1    = 1'b1;
            o_dec.re2    = (w_op == OP_SW);
            o_dec.wreg   = (w_op == OP_LW);
            o_dec.wd     = w_rt;
            o_dec.imm2   = {{16{w_imm[15]}}, w_imm};
         end
         default: begin
            o_dec.aluop = ALU_NOP;
         end
      endcase
      o_dec.wreg = o_dec.wreg & (o_dec.wd != NopRegAddr);
   end

endmodule

// File: rtl/id_stage.sv
// MIPS ID stage: decode, regfile read-port drive, EX/MEM operand forwarding,
// load-use stall request and the ID/EX pipeline register.
module id_stage
   import id_stage_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [INST_W-1:0]   id_pc_i,
   input  logic [INST_W-1:0]   id_inst_i,
   input  logic                stall_i,
   input  logic                flush_i,
   output logic                re1_o,
   output logic                re2_o,
   output logic [REG_AW-1:0]   raddr1_o,
   output logic [REG_AW-1:0]   raddr2_o,
   input  logic [INST_W-1:0]   rdata1_i,
   input  logic [INST_W-1:0]   rdata2_i,
   input  logic                ex_wreg_i,
   input  logic                ex_load_i,
   input  logic [REG_AW-1:0]   ex_wd_i,
   input  logic [INST_W-1:0]   ex_wdata_i,
   input  logic                mem_wreg_i,
   input  logic [REG_AW-1:0]   mem_wd_i,
   input  logic [INST_W-1:0]   mem_wdata_i,
   output logic                stallreq_o,
   output logic                ex_valid_o,
   output logic [ALUOP_W-1:0]  ex_aluop_o,
   output logic [ALUSEL_W-1:0] ex_alusel_o,
   output logic [INST_W-1:0]   ex_reg1_o,
   output logic [INST_W-1:0]   ex_reg2_o,
   output logic [REG_AW-1:0]   ex_wd_o,
   output logic                ex_wreg_o,
   output logic [INST_W-1:0]   ex_inst_o
);

   dec_t                w_dec;
   logic [INST_W-1:0]   w_reg1;
   logic [INST_W-1:0]   w_reg2;
   logic                w_load_hit;
   logic                w_bubble;
   logic                w_unused_pc;

   logic                r_valid;
   logic [ALUOP_W-1:0]  r_aluop;
   logic [ALUSEL_W-1:0] r_alusel;
   logic [INST_W-1:0]   r_reg1;
   logic [INST_W-1:0]   r_reg2;
   logic [REG_AW-1:0]   r_wd;
   logic                r_wreg;
   logic [INST_W-1:0]   r_inst;

   // The PC is carried for debug visibility upstream only.
   assign w_unused_pc = ^id_pc_i;

   id_decode u_decode (
      .i_inst (id_inst_i),
      .o_dec  (w_dec)
   );

   assign re1_o    = w_dec.re1;
   assign re2_o    = w_dec.re2;
   assign raddr1_o = w_dec.ra1;
   assign raddr2_o = w_dec.ra2;

   assign w_reg1 = sel_operand(w_dec.re1, w_dec.ra1, w_dec.imm1, ex_wreg_i, ex_wd_i, ex_wdata_i,
                               mem_wreg_i, mem_wd_i, mem_wdata_i, rdata1_i);
   assign w_reg2 = sel_operand(w_dec.re2, w_dec.ra2, w_dec.imm2, ex_wreg_i, ex_wd_i, ex_wdata_i,
                               mem_wreg_i, mem_wd_i, mem_wdata_i, rdata2_i);

   // A load in EX cannot forward its data yet, so a dependent ID must wait a cycle.
   assign w_load_hit = ex_load_i & ex_wreg_i & (ex_wd_i != NopRegAddr) &
                       ((w_dec.re1 & (w_dec.ra1 == ex_wd_i)) |
                        (w_dec.re2 & (w_dec.ra2 == ex_wd_i)));
   assign stallreq_o = w_load_hit;

   assign w_bubble = rst | flush_i | (~stall_i & w_load_hit);

   // ID/EX register: bubble beats hold, hold beats a fresh load.
   always_ff @(posedge clk) begin
      if (w_bubble) begin
         r_valid  <= 1'b0;
         r_aluop  <= ALU_NOP;
         r_alusel <= SEL_NOP;
         r_reg1   <= ZeroWord;
         r_reg2   <= ZeroWord;
         r_wd     <= NopRegAddr;
         r_wreg   <= 1'b0;
         r_inst   <= ZeroWord;
      end else if (!stall_i) begin
         r_valid  <= 1'b1;
         r_aluop  <= w_dec.aluop;
         r_alusel <= w_dec.alusel;
         r_reg1   <= w_reg1;
         r_reg2   <= w_reg2;
         r_wd     <= w_dec.wd;
         r_wreg   <= w_dec.wreg;
         r_inst   <= id_inst_i;
      end
   end

   assign ex_valid_o  = r_valid;
   assign ex_aluop_o  = r_aluop;
   assign ex_alusel_o = r_alusel;
   assign ex_reg1_o   = r_reg1;
   assign ex_reg2_o   = r_reg2;
   assign ex_wd_o     = r_wd;
   assign ex_wreg_o   = r_wreg;
   assign ex_inst_o   = r_inst;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed pipeline scenarios plus randomized
// traffic, checked against a mnemonic-level reference model.
module tb_id_stage;
   import id_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] id_pc_i = 32'h0, id_inst_i = 32'h0;
   logic        stall_i = 1'b0, flush_i = 1'b0;
   logic        re1_o, re2_o;
   logic [4:0]  raddr1_o, raddr2_o;
   logic [31:0] rdata1_i = 32'h0, rdata2_i = 32'h0;
   logic        ex_wreg_i = 1'b0, ex_load_i = 1'b0;
   logic [4:0]  ex_wd_i = 5'd0;
   logic [31:0] ex_wdata_i = 32'h0;
   logic        mem_wreg_i = 1'b0;
   logic [4:0]  mem_wd_i = 5'd0;
   logic [31:0] mem_wdata_i = 32'h0;
   logic        stallreq_o, ex_valid_o, ex_wreg_o;
   logic [7:0]  ex_aluop_o;
   logic [2:0]  ex_alusel_o;
   logic [31:0] ex_reg1_o, ex_reg2_o, ex_inst_o;
   logic [4:0]  ex_wd_o;

   id_stage dut (
      .clk(clk), .rst(rst), .id_pc_i(id_pc_i), .id_inst_i(id_inst_i),
      .stall_i(stall_i), .flush_i(flush_i),
      .re1_o(re1_o), .re2_o(re2_o), .raddr1_o(raddr1_o), .raddr2_o(raddr2_o),
      .rdata1_i(rdata1_i), .rdata2_i(rdata2_i),
      .ex_wreg_i(ex_wreg_i), .ex_load_i(ex_load_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
      .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
      .stallreq_o(stallreq_o), .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o),
      .ex_alusel_o(ex_alusel_o), .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
      .ex_wd_o(ex_wd_o), .ex_wreg_o(ex_wreg_o), .ex_inst_o(ex_inst_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, flush, stall;
      logic [31:0] inst, pc, rd1, rd2;
      logic ex_wreg, ex_load;
      logic [4:0] ex_wd;
      logic [31:0] ex_wdata;
      logic mem_wreg;
      logic [4:0] mem_wd;
      logic [31:0] mem_wdata;
   } stim_t;

   typedef struct packed {
      logic stall; logic re1; logic re2; logic [4:0] ra1; logic [4:0] ra2;
   } comb_t;

   typedef struct packed {
      logic valid; logic [7:0] aluop; logic [2:0] alusel;
      logic [31:0] reg1; logic [31:0] reg2; logic [4:0] wd; logic wreg; logic [31:0] inst;
   } st_t;

   typedef struct packed {
      logic [7:0] aluop; logic [2:0] sel; logic re1; logic re2; logic wreg;
      logic [4:0] wd; logic [31:0] imm1; logic [31:0] imm2;
   } md_t;

   comb_t comb_q[$];
   st_t   reg_q[$];
   st_t   m_st;
   int    n_tests = 0;
   int    n_fail  = 0;

   // Reference decode: classify by mnemonic, then apply that format's operand rules.
   function automatic md_t model_dec(input logic [31:0] inst);
      md_t m;
      logic [5:0] op, fn;
      logic [4:0] rt, rd, sa;
      logic [15:0] imm;
      string kind;
      op = inst[31:26]; rt = inst[20:16]; rd = inst[15:11];
      sa = inst[10:6];  fn = inst[5:0];   imm = inst[15:0];
      m = '0;
      kind = "NOP";
      if (op == 6'h00) begin
         case (fn)
            6'h24: begin kind = "R3"; m.aluop = ALU_AND;  m.sel = SEL_LOGIC; end
            6'h25: begin kind = "R3"; m.aluop = ALU_OR;   m.sel = SEL_LOGIC; end
            6'h26: begin kind = "R3"; m.aluop = ALU_XOR;  m.sel = SEL_LOGIC; end
            6'h27: begin kind = "R3"; m.aluop = ALU_NOR;  m.sel = SEL_LOGIC; end
            6'h21: begin kind = "R3"; m.aluop = ALU_ADDU; m.sel = SEL_ARITH; end
            6'h23: begin kind = "R3"; m.aluop = ALU_SUBU; m.sel = SEL_ARITH; end
            6'h2a: begin kind = "R3"; m.aluop = ALU_SLT;  m.sel = SEL_ARITH; end
            6'h00: begin kind = "SH"; m.aluop = ALU_SLL;  m.sel = SEL_SHIFT; end
            6'h02: begin kind = "SH"; m.aluop = ALU_SRL;  m.sel = SEL_SHIFT; end
            6'h03: begin kind = "SH"; m.aluop = ALU_SRA;  m.sel = SEL_SHIFT; end
            default: kind = "NOP";
         endcase
      end else begin
         case (op)
            6'h0d: begin kind = "IZ";  m.aluop = ALU_OR;    m.sel = SEL_LOGIC; end
            6'h0c: begin kind = "IZ";  m.aluop = ALU_AND;   m.sel = SEL_LOGIC; end
            6'h0e: begin kind = "IZ";  m.aluop = ALU_XOR;   m.sel = SEL_LOGIC; end
            6'h09: begin kind = "IS";  m.aluop = ALU_ADDIU; m.sel = SEL_ARITH; end
            6'h0f: begin kind = "LUI"; m.aluop = ALU_OR;    m.sel = SEL_LOGIC; end
            6'h23: begin kind = "IS";  m.aluop = ALU_LW;    m.sel = SEL_LDST;  end
            6'h2b: begin kind = "SW";  m.aluop = ALU_SW;    m.sel = SEL_LDST;  end
            default: kind = "NOP";
         endcase
      end
      case (kind)
         "R3":  begin m.re1 = 1; m.re2 = 1; m.wd = rd; end
         "SH":  begin m.re2 = 1; m.wd = rd; m.imm1 = 32'(sa); end
         "IZ":  begin m.re1 = 1; m.wd = rt; m.imm2 = 32'(imm); end
         "IS":  begin m.re1 = 1; m.wd = rt; m.imm2 = 32'(signed'(imm)); end
         "LUI": begin m.wd = rt; m.imm2 = {imm, 16'h0000}; end
         "SW":  begin m.re1 = 1; m.re2 = 1; m.wd = rt; m.imm2 = 32'(signed'(imm)); end
         default: m.aluop = ALU_NOP;
      endcase
      m.wreg = (kind != "NOP") && (kind != "SW") && (m.wd != 5'd0);
      return m;
   endfunction

   function automatic logic [31:0] model_opnd(input logic re, input logic [4:0] a,
                                              input logic [31:0] imm, input logic [31:0] rd,
                                              input stim_t s);
      if (!re) return imm;
      if (a == 5'd0) return 32'h0;
      if (s.ex_wreg && s.ex_wd == a) return s.ex_wdata;
      if (s.mem_wreg && s.mem_wd == a) return s.mem_wdata;
      return rd;
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '{default: '0};
      return s;
   endfunction

   task automatic step(input stim_t s);
      md_t   m;
      comb_t c;
      logic [4:0] rs, rt;
      @(negedge clk);
      rst = s.rst; flush_i = s.flush; stall_i = s.stall; id_inst_i = s.inst; id_pc_i = s.pc;
      rdata1_i = s.rd1; rdata2_i = s.rd2;
      ex_wreg_i = s.ex_wreg; ex_load_i = s.ex_load; ex_wd_i = s.ex_wd; ex_wdata_i = s.ex_wdata;
      mem_wreg_i = s.mem_wreg; mem_wd_i = s.mem_wd; mem_wdata_i = s.mem_wdata;
      m  = model_dec(s.inst);
      rs = s.inst[25:21];
      rt = s.inst[20:16];
      c.re1 = m.re1; c.re2 = m.re2; c.ra1 = rs; c.ra2 = rt;
      c.stall = s.ex_load && s.ex_wreg && (s.ex_wd != 5'd0) &&
                ((m.re1 && rs == s.ex_wd) || (m.re2 && rt == s.ex_wd));
      comb_q.push_back(c);
      if (s.rst || s.flush) m_st = '0;
      else if (s.stall) m_st = m_st;
      else if (c.stall) m_st = '0;
      else m_st = '{1'b1, m.aluop, m.sel, model_opnd(m.re1, rs, m.imm1, s.rd1, s),
                    model_opnd(m.re2, rt, m.imm2, s.rd2, s), m.wd, m.wreg, s.inst};
      reg_q.push_back(m_st);
   endtask

   // Combinational monitor: checks read ports and stall request mid-cycle.
   always begin
      comb_t c, a;
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
         c = comb_q.pop_front();
         a = '{stallreq_o, re1_o, re2_o, raddr1_o, raddr2_o};
         n_tests++;
         if (a !== c) begin
            n_fail++;
            $display("FAIL comb t=%0t: got stall=%b re=%b%b ra=%0d/%0d, want stall=%b re=%b%b ra=%0d/%0d",
                     $time, a.stall, a.re1, a.re2, a.ra1, a.ra2, c.stall, c.re1, c.re2, c.ra1, c.ra2);
         end
      end
   end

   // ID/EX monitor: checks the registered outputs just after each edge.
   always begin
      st_t e, a;
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
         e = reg_q.pop_front();
         a = '{ex_valid_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o, ex_wd_o, ex_wreg_o, ex_inst_o};
         n_tests++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL idex t=%0t: got v=%b op=%h sel=%h r1=%h r2=%h wd=%0d wr=%b inst=%h, want v=%b op=%h sel=%h r1=%h r2=%h wd=%0d wr=%b inst=%h",
                     $time, a.valid, a.aluop, a.alusel, a.reg1, a.reg2, a.wd, a.wreg, a.inst,
                     e.valid, e.aluop, e.alusel, e.reg1, e.reg2, e.wd, e.wreg, e.inst);
         end
      end
   end

   function automatic logic [31:0] rand_inst();
      logic [4:0] rs, rt, rd;
      logic [5:0] fns [10];
      logic [5:0] ops [7];
      int k;
      fns = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23, 6'h2a, 6'h00, 6'h02, 6'h03};
      ops = '{6'h0d, 6'h0c, 6'h0e, 6'h09, 6'h0f, 6'h23, 6'h2b};
      rs = 5'($urandom_range(0, 4)); rt = 5'($urandom_range(0, 4)); rd = 5'($urandom_range(0, 4));
      k = $urandom_range(0, 18);
      if (k < 10) return {6'h00, rs, rt, rd, 5'($urandom), fns[k]};
      if (k < 17) return {ops[k-10], rs, rt, 16'($urandom)};
      return $urandom;
   endfunction

   initial begin
      stim_t s;
      int    budget;
      m_st = '0;
      s = idle(); s.rst = 1'b1;
      step(s); step(s);
      // ORI $1,$0,0x1100 from an empty regfile
      s = idle(); s.inst = {6'h0d, 5'd0, 5'd1, 16'h1100};
      step(s);
      // ADDU $3,$1,$2 with EX/MEM forwarding, then both stages targeting $1
      s = idle(); s.inst = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
      s.ex_wreg = 1'b1; s.ex_wd = 5'd1; s.ex_wdata = 32'h5;
      s.mem_wreg = 1'b1; s.mem_wd = 5'd2; s.mem_wdata = 32'h7;
      step(s);
      s.mem_wd = 5'd1; s.mem_wdata = 32'h9;
      step(s);
      // Load-use: LW $4 in EX, OR $5,$4,$4 in ID; then sources $0
      s = idle(); s.ex_load = 1'b1; s.ex_wreg = 1'b1; s.ex_wd = 5'd4;
      s.inst = {6'h00, 5'd4, 5'd4, 5'd5, 5'd0, 6'h25};
      step(s);
      s.inst = {6'h00, 5'd0, 5'd0, 5'd5, 5'd0, 6'h25};
      step(s);
      // Hold for three cycles with changing ID, then flush during stall
      s = idle(); s.inst = {6'h0d, 5'd0, 5'd2, 16'hBEEF};
      step(s);
      for (int i = 0; i < 3; i++) begin
         s = idle(); s.stall = 1'b1; s.inst = rand_inst(); s.rd1 = $urandom; s.rd2 = $urandom;
         step(s);
      end
      s.flush = 1'b1;
      step(s);
      // LUI, ADDIU sign extension, SW
      s = idle(); s.inst = {6'h0f, 5'd0, 5'd6, 16'h8000}; step(s);
      s.inst = {6'h09, 5'd0, 5'd7, 16'hFFFF}; step(s);
      s.inst = {6'h2b, 5'd1, 5'd2, 16'h0004}; s.rd1 = 32'h100; s.rd2 = 32'hCAFE; step(s);
      // Reset mid-stream, then undefined opcode 0x3F
      s = idle(); s.inst = {6'h0d, 5'd0, 5'd1, 16'h1234}; step(s);
      s.rst = 1'b1; step(s);
      s = idle(); s.inst = 32'hFC00_0000; s.rd1 = 32'h1; s.rd2 = 32'h2; step(s);
      // Randomized traffic with a small register pool to provoke hazards
      for (int i = 0; i < 400; i++) begin
         s.rst      = ($urandom_range(0, 49) == 0);
         s.flush    = ($urandom_range(0, 9) == 0);
         s.stall    = ($urandom_range(0, 5) == 0);
         s.inst     = rand_inst();
         s.pc       = $urandom;
         s.rd1      = $urandom;
         s.rd2      = $urandom;
         s.ex_wreg  = 1'($urandom);
         s.ex_load  = ($urandom_range(0, 3) == 0);
         s.ex_wd    = 5'($urandom_range(0, 4));
         s.ex_wdata = $urandom;
         s.mem_wreg = 1'($urandom);
         s.mem_wd   = 5'($urandom_range(0, 4));
         s.mem_wdata = $urandom;
         step(s);
      end
      budget = 0;
      while ((comb_q.size() > 0 || reg_q.size() > 0) && budget < 10) begin
         @(negedge clk);
         budget++;
      end
      #3;
      if (comb_q.size() > 0 || reg_q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d comb and %0d idex expectations left, want 0", comb_q.size(), reg_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
